// File: rtl/bnn_conv_multi_oc_if.sv
// Handshake and data bundle between the layer controller and the binary convolution engine.
// Pure wiring, no latency; all maps are wide packed vectors, bit r*side+c per channel.
// No backpressure: start is a request, busy/done report progress back to the controller.
interface bnn_conv_multi_oc_if #(
  parameter int IC     = 8,
  parameter int OC     = 4,
  parameter int K      = 3,
  parameter int IMG_IN = 30
);
  localparam int IMG_OUT = IMG_IN - K + 1;
  localparam int ACC_W   = $clog2(IC * K * K) + 2;

  logic                                      start;
  logic [IC-1:0][IMG_IN*IMG_IN-1:0]          img_in;
  logic [OC*IC*K*K-1:0]                      weights;
  logic [OC-1:0][ACC_W-1:0]                  thresh;
  logic [OC-1:0][IMG_OUT*IMG_OUT-1:0]        img_out;
  logic                                      busy;
  logic                                      done;

  modport master (
    output start, img_in, weights, thresh,
    input  img_out, busy, done
  );

  modport slave (
    input  start, img_in, weights, thresh,
    output img_out, busy, done
  );
endinterface

// File: rtl/bnn_conv_multi_oc.sv
// Sequential XNOR-popcount KxK convolution, IC binary maps in, OC binary maps out (optional macro BNN_CONV_THRESH_EN).
// Latency start->done = IMG_OUT*IMG_OUT*OC*IC + 2 cycles; one (pixel, oc, ic) step per cycle.
// No backpressure: start is only sampled in IDLE; inputs must be held stable while busy.
module bnn_conv_multi_oc #(
  parameter int IC     = 8,
  parameter int OC     = 4,
  parameter int K      = 3,
  parameter int IMG_IN = 30
) (
  input logic                clk,
  input logic                rst,
  bnn_conv_multi_oc_if.slave bus
);
  localparam int IMG_OUT = IMG_IN - K + 1;
  localparam int KK      = K * K;
  localparam int ACC_W   = $clog2(IC * KK) + 2;
  localparam int ICW     = (IC > 1) ? $clog2(IC) : 1;
  localparam int OCW     = (OC > 1) ? $clog2(OC) : 1;
  localparam int POSW    = (IMG_OUT > 1) ? $clog2(IMG_OUT) : 1;
  localparam int PIX_W   = (IMG_IN * IMG_IN > 1) ? $clog2(IMG_IN * IMG_IN) : 1;
  localparam int OUT_W   = (IMG_OUT * IMG_OUT > 1) ? $clog2(IMG_OUT * IMG_OUT) : 1;
  localparam int WB_W    = (OC * IC * KK > 1) ? $clog2(OC * IC * KK) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                             state_q, state_d;
  logic [POSW-1:0]                    row_q, col_q;
  logic [OCW-1:0]                     oc_q;
  logic [ICW-1:0]                     ic_q;
  logic signed [ACC_W-1:0]            acc_q;
  logic signed [ACC_W-1:0]            acc_next;
  logic [ACC_W-1:0]                   pop;
  logic                               match_bit;
  logic                               out_bit;
  logic [OC-1:0][IMG_OUT*IMG_OUT-1:0] img_out_q;

  logic last_ic, last_oc, last_col, last_row, last_step;

  assign last_ic   = (ic_q == ICW'(IC - 1));
  assign last_oc   = (oc_q == OCW'(OC - 1));
  assign last_col  = (col_q == POSW'(IMG_OUT - 1));
  assign last_row  = (row_q == POSW'(IMG_OUT - 1));
  assign last_step = last_ic & last_oc & last_col & last_row;

  // Count matching bits between the current KxK window of channel ic and the weight slice of (oc, ic).
  always_comb begin
    pop       = '0;
    match_bit = 1'b0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        match_bit = bus.img_in[ic_q][PIX_W'((int'(row_q) + i) * IMG_IN + int'(col_q) + j)]
                    ~^ bus.weights[WB_W'(((int'(oc_q) * IC + int'(ic_q)) * K + i) * K + j)];
        pop       = pop + ACC_W'(match_bit);
      end
    end
  end

  // Each step contributes 2*matches - K*K; the true sum always fits ACC_W, so modular add is exact.
  assign acc_next = acc_q + $signed(pop << 1) - $signed(ACC_W'(KK));

`ifdef BNN_CONV_THRESH_EN
  assign out_bit = (acc_next >= $signed(bus.thresh[oc_q]));
`else
  // Sign activation: a zero sum counts as non-negative and yields 1.
  assign out_bit = ~acc_next[ACC_W-1];
  logic unused_thresh;
  assign unused_thresh = ^bus.thresh;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one RUN sweep, one FLUSH cycle that carries the done pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_step) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: loop counters (ic innermost, row outermost), accumulator and output map writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      oc_q      <= '0;
      ic_q      <= '0;
      acc_q     <= '0;
      img_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            row_q     <= '0;
            col_q     <= '0;
            oc_q      <= '0;
            ic_q      <= '0;
            acc_q     <= '0;
            img_out_q <= '0;
          end
        end
        RUN: begin
          if (last_ic) begin
            acc_q <= '0;
            img_out_q[oc_q][OUT_W'(int'(row_q) * IMG_OUT + int'(col_q))] <= out_bit;
            ic_q  <= '0;
            if (last_oc) begin
              oc_q <= '0;
              if (last_col) begin
                col_q <= '0;
                if (last_row) row_q <= '0;
                else          row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end else begin
              oc_q <= oc_q + 1'b1;
            end
          end else begin
            acc_q <= acc_next;
            ic_q  <= ic_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == FLUSH);
  assign bus.img_out = img_out_q;
endmodule

// File: tb/tb_bnn_conv_multi_oc.sv
// Bench for the binary convolution engine: four instances with different geometries share
// one set of stimulus arrays; a per-pixel sum-of-terms model supplies every expected map.
module tb_bnn_conv_multi_oc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   sel = 0;
  int   cur_ic = 8, cur_oc = 4, cur_k = 3, cur_in = 30;

  bit   g_img [8][900];
  bit   g_w   [4][8][9];
  int   g_thr [4];
  bit   g_exp [4][784];
  bit   g_out [4][784];
  logic done_s, busy_s;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bnn_conv_multi_oc_if                                      ifb ();
  bnn_conv_multi_oc_if #(.IC(8), .OC(2), .K(3), .IMG_IN(6)) ifs ();
  bnn_conv_multi_oc_if #(.IC(2), .OC(2), .K(3), .IMG_IN(4)) ift ();
  bnn_conv_multi_oc_if #(.IC(1), .OC(1), .K(1), .IMG_IN(4)) ifk ();

  bnn_conv_multi_oc                                      u_big (.clk(clk), .rst(rst), .bus(ifb));
  bnn_conv_multi_oc #(.IC(8), .OC(2), .K(3), .IMG_IN(6)) u_sml (.clk(clk), .rst(rst), .bus(ifs));
  bnn_conv_multi_oc #(.IC(2), .OC(2), .K(3), .IMG_IN(4)) u_tie (.clk(clk), .rst(rst), .bus(ift));
  bnn_conv_multi_oc #(.IC(1), .OC(1), .K(1), .IMG_IN(4)) u_k1  (.clk(clk), .rst(rst), .bus(ifk));

  // Broadcast the shared stimulus arrays to every instance; start goes only to the selected one.
  always_comb begin
    ifb.start = start && (sel == 0);
    for (int c = 0; c < 8; c++) for (int p = 0; p < 900; p++) ifb.img_in[c][p] = g_img[c][p];
    for (int o = 0; o < 4; o++) for (int c = 0; c < 8; c++) for (int t = 0; t < 9; t++)
      ifb.weights[(o*8+c)*9+t] = g_w[o][c][t];
    for (int o = 0; o < 4; o++) ifb.thresh[o] = 9'(g_thr[o]);
  end
  always_comb begin
    ifs.start = start && (sel == 1);
    for (int c = 0; c < 8; c++) for (int p = 0; p < 36; p++) ifs.img_in[c][p] = g_img[c][p];
    for (int o = 0; o < 2; o++) for (int c = 0; c < 8; c++) for (int t = 0; t < 9; t++)
      ifs.weights[(o*8+c)*9+t] = g_w[o][c][t];
    for (int o = 0; o < 2; o++) ifs.thresh[o] = 9'(g_thr[o]);
  end
  always_comb begin
    ift.start = start && (sel == 2);
    for (int c = 0; c < 2; c++) for (int p = 0; p < 16; p++) ift.img_in[c][p] = g_img[c][p];
    for (int o = 0; o < 2; o++) for (int c = 0; c < 2; c++) for (int t = 0; t < 9; t++)
      ift.weights[(o*2+c)*9+t] = g_w[o][c][t];
    for (int o = 0; o < 2; o++) ift.thresh[o] = 7'(g_thr[o]);
  end
  always_comb begin
    ifk.start = start && (sel == 3);
    for (int p = 0; p < 16; p++) ifk.img_in[0][p] = g_img[0][p];
    ifk.weights[0] = g_w[0][0][0];
    ifk.thresh[0]  = 2'(g_thr[0]);
  end

  // Observe the selected instance.
  always_comb begin
    done_s = 1'b0;
    busy_s = 1'b0;
    for (int o = 0; o < 4; o++) for (int p = 0; p < 784; p++) g_out[o][p] = 1'b0;
    case (sel)
      0: begin
        done_s = ifb.done; busy_s = ifb.busy;
        for (int o = 0; o < 4; o++) for (int p = 0; p < 784; p++) g_out[o][p] = ifb.img_out[o][p];
      end
      1: begin
        done_s = ifs.done; busy_s = ifs.busy;
        for (int o = 0; o < 2; o++) for (int p = 0; p < 16; p++) g_out[o][p] = ifs.img_out[o][p];
      end
      2: begin
        done_s = ift.done; busy_s = ift.busy;
        for (int o = 0; o < 2; o++) for (int p = 0; p < 4; p++) g_out[o][p] = ift.img_out[o][p];
      end
      default: begin
        done_s = ifk.done; busy_s = ifk.busy;
        for (int p = 0; p < 16; p++) g_out[0][p] = ifk.img_out[0][p];
      end
    endcase
  end

  task automatic select(input int s);
    sel = s;
    case (s)
      0:       begin cur_ic = 8; cur_oc = 4; cur_k = 3; cur_in = 30; end
      1:       begin cur_ic = 8; cur_oc = 2; cur_k = 3; cur_in = 6;  end
      2:       begin cur_ic = 2; cur_oc = 2; cur_k = 3; cur_in = 4;  end
      default: begin cur_ic = 1; cur_oc = 1; cur_k = 1; cur_in = 4;  end
    endcase
  endtask

  function automatic int n_steps();
    return (cur_in - cur_k + 1) * (cur_in - cur_k + 1) * cur_oc * cur_ic;
  endfunction

  function automatic void fill_const(input bit img_v, input bit w_v);
    for (int c = 0; c < 8; c++) for (int p = 0; p < 900; p++) g_img[c][p] = img_v;
    for (int o = 0; o < 4; o++) begin
      g_thr[o] = 0;
      for (int c = 0; c < 8; c++) for (int t = 0; t < 9; t++) g_w[o][c][t] = w_v;
    end
  endfunction

  function automatic void fill_random();
    fill_const(1'b0, 1'b0);
    for (int c = 0; c < cur_ic; c++) for (int p = 0; p < cur_in*cur_in; p++)
      g_img[c][p] = 1'($urandom_range(0, 1));
    for (int o = 0; o < cur_oc; o++) begin
      g_thr[o] = int'($urandom_range(0, 12)) - 6;
      for (int c = 0; c < cur_ic; c++) for (int t = 0; t < cur_k*cur_k; t++)
        g_w[o][c][t] = 1'($urandom_range(0, 1));
    end
  endfunction

  // Reference: each output pixel is the whole-sum over channels of (matches - mismatches).
  function automatic void model();
    int n_out, acc, pop;
    bit b;
    n_out = cur_in - cur_k + 1;
    for (int o = 0; o < 4; o++) for (int p = 0; p < 784; p++) g_exp[o][p] = 1'b0;
    for (int o = 0; o < cur_oc; o++)
      for (int r = 0; r < n_out; r++)
        for (int c = 0; c < n_out; c++) begin
          acc = 0;
          for (int ch = 0; ch < cur_ic; ch++) begin
            pop = 0;
            for (int i = 0; i < cur_k; i++)
              for (int j = 0; j < cur_k; j++)
                if (g_img[ch][(r+i)*cur_in + c + j] == g_w[o][ch][i*cur_k + j]) pop++;
            acc += pop - (cur_k*cur_k - pop);
          end
`ifdef BNN_CONV_THRESH_EN
          b = (acc >= g_thr[o]);
`else
          b = (acc >= 0);
`endif
          g_exp[o][r*n_out + c] = b;
        end
  endfunction

  function automatic int count_diff();
    int n = 0;
    for (int o = 0; o < 4; o++) for (int p = 0; p < 784; p++) if (g_out[o][p] != g_exp[o][p]) n++;
    return n;
  endfunction

  function automatic int count_ones();
    int n = 0;
    for (int o = 0; o < 4; o++) for (int p = 0; p < 784; p++) if (g_out[o][p]) n++;
    return n;
  endfunction

  // Pulse start, then count cycles (start cycle = 1) until done, bounded.
  task automatic run_pass(output int cyc);
    int lim;
    lim = n_steps() + 20;
    cyc = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done_s || cyc >= lim) break;
    end
  endtask

  task automatic test_reset();
    select(0);
    @(negedge clk);
    n_checks++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b need 0", busy_s); end
    n_checks++; if (done_s !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b need 0", done_s); end
    n_checks++; if (count_ones() !== 0) begin n_err++; $display("FAIL reset_out: ones %0d need 0", count_ones()); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_match();
    int cyc;
    select(0);
    fill_const(1'b1, 1'b1);
    model();
    run_pass(cyc);
    n_checks++; if (cyc !== 28*28*4*8 + 2) begin n_err++; $display("FAIL match_latency: got %0d need %0d", cyc, 28*28*4*8+2); end
    n_checks++; if (count_diff() !== 0) begin n_err++; $display("FAIL match_map: %0d bits differ, need 0", count_diff()); end
    n_checks++; if (count_ones() !== 4*784) begin n_err++; $display("FAIL match_ones: got %0d need %0d", count_ones(), 4*784); end
    @(negedge clk);
    n_checks++; if (done_s !== 1'b0) begin n_err++; $display("FAIL match_done_pulse: got %0b need 0", done_s); end
    n_checks++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL match_idle: busy %0b need 0", busy_s); end
  endtask

  task automatic test_reset_mid_run();
    int dcount = 0;
    select(0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (200) @(negedge clk);
    n_checks++; if (busy_s !== 1'b1) begin n_err++; $display("FAIL midrun_busy: got %0b need 1", busy_s); end
    // 199 steps done; one bit per 8 channel steps.
    n_checks++; if (count_ones() !== 24) begin n_err++; $display("FAIL midrun_progress: ones %0d need 24", count_ones()); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %0b need 0", busy_s); end
    n_checks++; if (done_s !== 1'b0) begin n_err++; $display("FAIL abort_done: got %0b need 0", done_s); end
    n_checks++; if (count_ones() !== 0) begin n_err++; $display("FAIL abort_out: ones %0d need 0", count_ones()); end
    @(negedge clk);
    rst = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done_s) dcount++;
    end
    n_checks++; if (dcount !== 0) begin n_err++; $display("FAIL abort_no_done: saw %0d pulses need 0", dcount); end
    n_checks++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL abort_stays_idle: busy %0b need 0", busy_s); end
  endtask

  task automatic test_tie();
    int cyc;
    bit want1;
    select(2);
    fill_const(1'b1, 1'b0);
    for (int o = 0; o < 2; o++) for (int t = 0; t < 9; t++) g_w[o][0][t] = 1'b1;
    g_thr[1] = 1;
    model();
    run_pass(cyc);
`ifdef BNN_CONV_THRESH_EN
    want1 = 1'b0;
`else
    want1 = 1'b1;
`endif
    n_checks++; if (cyc !== 2*2*2*2 + 2) begin n_err++; $display("FAIL tie_latency: got %0d need %0d", cyc, 18); end
    n_checks++; if (count_diff() !== 0) begin n_err++; $display("FAIL tie_map: %0d bits differ, need 0", count_diff()); end
    n_checks++; if (g_out[0][0] !== 1'b1) begin n_err++; $display("FAIL tie_zero_sum: got %0b need 1", g_out[0][0]); end
    n_checks++; if (g_out[1][3] !== want1) begin n_err++; $display("FAIL tie_thresh: got %0b need %0b", g_out[1][3], want1); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc;
    for (int s = 1; s <= 3; s += 2) begin
      select(s);
      for (int round = 0; round < 4; round++) begin
        fill_random();
        model();
        run_pass(cyc);
        n_checks++; if (cyc !== n_steps() + 2) begin n_err++; $display("FAIL rand_latency[%0d.%0d]: got %0d need %0d", s, round, cyc, n_steps()+2); end
        n_checks++; if (count_diff() !== 0) begin n_err++; $display("FAIL rand_map[%0d.%0d]: %0d bits differ, need 0", s, round, count_diff()); end
        @(negedge clk);
        n_checks++; if (done_s !== 1'b0) begin n_err++; $display("FAIL rand_done_pulse[%0d.%0d]: got %0b need 0", s, round, done_s); end
      end
    end
  endtask

  task automatic test_all_mismatch();
    int cyc;
    select(1);
    fill_const(1'b1, 1'b0);
    model();
    run_pass(cyc);
    n_checks++; if (cyc !== 16*2*8 + 2) begin n_err++; $display("FAIL mismatch_latency: got %0d need %0d", cyc, 258); end
    n_checks++; if (count_ones() !== 0) begin n_err++; $display("FAIL mismatch_ones: got %0d need 0", count_ones()); end
    n_checks++; if (count_diff() !== 0) begin n_err++; $display("FAIL mismatch_map: %0d bits differ, need 0", count_diff()); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, n, k;
    select(1);
    fill_random();
    model();
    n = n_steps();
    cyc = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done_s || cyc >= n + 20) break;
      if (cyc == 50) start = 1'b1;
      if (cyc == 51) start = 1'b0;
      if (cyc == n)  start = 1'b1;
    end
    n_checks++; if (cyc !== n + 2) begin n_err++; $display("FAIL b2b_latency: got %0d need %0d", cyc, n+2); end
    n_checks++; if (count_diff() !== 0) begin n_err++; $display("FAIL b2b_map1: %0d bits differ, need 0", count_diff()); end
    @(negedge clk);
    n_checks++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap: busy %0b done %0b need 0 0", busy_s, done_s); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy_s !== 1'b1) begin n_err++; $display("FAIL b2b_restart: busy %0b need 1", busy_s); end
    n_checks++; if (count_ones() !== 0) begin n_err++; $display("FAIL b2b_clear: ones %0d need 0", count_ones()); end
    k = 1;
    while (k < n + 20) begin
      @(negedge clk);
      k++;
      if (done_s) break;
    end
    n_checks++; if (k !== n + 1) begin n_err++; $display("FAIL b2b_latency2: got %0d need %0d", k, n+1); end
    n_checks++; if (count_diff() !== 0) begin n_err++; $display("FAIL b2b_map2: %0d bits differ, need 0", count_diff()); end
    @(negedge clk);
  endtask

  initial begin
    fill_const(1'b0, 1'b0);
    test_reset();
    test_all_match();
    test_reset_mid_run();
    test_tie();
    test_random();
    test_all_mismatch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
